uart_tx: RTL and testbench

//   Serial UART transmitter with a one-entry holding register. Serialises parallel bytes onto txd.

---
 rtl/uart_tx.sv | 202 ++++++++++++++++++++
 tb/tb_uart_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter with a one-entry holding register.
//
// A producer writes a byte into the holding register. When the shifter is
// free, the byte moves into it and is sent on txd as one frame:
// start bit (0), DATA_BITS data bits LSB first, an optional parity bit, and
// STOP_BITS stop bits (1). Each bit lasts DIVISOR clk cycles. A second byte
// may be written while the first is still shifting. It then follows with no
// idle gap between the two frames.
//
// Parameters:
//   DIVISOR    clk cycles per serial bit (>= 2)
//   DATA_BITS  data bits per frame (5..8)
//   PARITY     0 = none, 1 = even, 2 = odd
//   STOP_BITS  1 or 2
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous reset, active-high
//   txdata   byte to send, sampled only on an accepted write
//   write    write strobe, accepted only while txempty = 1
//   txempty  1 = holding register free
//   busy     1 = a frame is being shifted out (START..STOP)
//   txd      serial line, idles high, driven straight from a flop
module uart_tx #(
  parameter int DIVISOR   = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] txdata,
  input  logic                 write,
  output logic                 txempty,
  output logic                 busy,
  output logic                 txd
);

  localparam int CW = $clog2(DIVISOR);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DIVISOR - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic                   stop_q, stop_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   hold_q, hold_d;
  logic                   hold_valid_q, hold_valid_d;
  logic                   par_q, par_d;       // even parity of the frame's data
  logic                   txd_q, txd_d;
  logic                   busy_q, busy_d;
  logic                   load;               // move holding register into shifter

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    stop_d       = stop_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    par_d        = par_q;
    txd_d        = txd_q;
    load         = 1'b0;

    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (hold_valid_q) load = 1'b1;
      end

      S_START: begin
        if (cnt_q == '0) begin
          state_d = S_DATA;
          txd_d   = shift_q[0];
          bit_d   = '0;
          cnt_d   = CNT_MAX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = CNT_MAX;
          if (bit_q == LAST_BIT) begin
            if (PARITY != 0) begin
              state_d = S_PAR;
              txd_d   = (PARITY == 2) ? ~par_q : par_q;
            end else begin
              state_d = S_STOP;
              txd_d   = 1'b1;
              stop_d  = 1'b0;
            end
          end else begin
            // Bit 1 is the next bit out once the shift has taken effect.
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
            bit_d   = bit_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_PAR: begin
        if (cnt_q == '0) begin
          state_d = S_STOP;
          txd_d   = 1'b1;
          stop_d  = 1'b0;
          cnt_d   = CNT_MAX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_STOP: begin
        if (cnt_q == '0) begin
          if (stop_q == STOP_LAST) begin
            // A waiting byte starts right away, so there is no idle bit
            // between the two frames.
            if (hold_valid_q) load = 1'b1;
            else              state_d = S_IDLE;
          end else begin
            stop_d = 1'b1;
            cnt_d  = CNT_MAX;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (load) begin
      state_d      = S_START;
      shift_d      = hold_q;
      hold_valid_d = 1'b0;
      txd_d        = 1'b0;
      cnt_d        = CNT_MAX;
      par_d        = ^hold_q;
    end

    // A load needs hold_valid_q = 1, so it can never fall in the same cycle
    // as an accepted write.
    if (write && !hold_valid_q) begin
      hold_d       = txdata;
      hold_valid_d = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments, so every flop takes
  // the value from before the edge, whatever order the statements are in.
  // NOTE: the data registers (shift_q, hold_q) are reset along with the
  // control state, so nothing in the block ever holds X after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      stop_q       <= 1'b0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      par_q        <= 1'b0;
      txd_q        <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      stop_q       <= stop_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      par_q        <= par_d;
      txd_q        <= txd_d;
      busy_q       <= busy_d;
    end
  end

  assign txempty = ~hold_valid_q;
  assign busy    = busy_q;
  assign txd     = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
//
// Three instances run with DIVISOR = 4:
//   u0  no parity,   1 stop bit
//   u1  even parity, 1 stop bit
//   u2  odd parity,  2 stop bits
// Expected frames are hand-written bit vectors. Bit 0 is the first bit on
// the line (the start bit). txd is sampled on every falling clock edge, so
// both the bit values and the exact length of each bit are checked.
module tb_uart_tx;

  localparam int DIV = 4;

  logic       clk;
  logic       rst;
  logic [7:0] txdata0, txdata1, txdata2;
  logic       write0, write1, write2;
  logic       txempty0, txempty1, txempty2;
  logic       busy0, busy1, busy2;
  logic       txd0, txd1, txd2;

  uart_tx #(.DIVISOR(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .txdata(txdata0), .write(write0),
    .txempty(txempty0), .busy(busy0), .txd(txd0));

  uart_tx #(.DIVISOR(DIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .txdata(txdata1), .write(write1),
    .txempty(txempty1), .busy(busy1), .txd(txd1));

  uart_tx #(.DIVISOR(DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .txdata(txdata2), .write(write2),
    .txempty(txempty2), .busy(busy2), .txd(txd2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs of the instance chosen by sel.
  int   sel;
  logic txd_s, busy_s, txempty_s;
  always_comb begin
    txd_s     = txd0;
    busy_s    = busy0;
    txempty_s = txempty0;
    case (sel)
      1: begin txd_s = txd1; busy_s = busy1; txempty_s = txempty1; end
      2: begin txd_s = txd2; busy_s = busy2; txempty_s = txempty2; end
      default: ;
    endcase
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // Recorded by capture() when it sees the start bit.
  int   start_wait;
  logic start_txempty;
  logic start_busy;

  typedef struct {
    int          sel;
    logic [7:0]  data;
    int          nbits;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Call at a falling edge. The write is seen by exactly one rising edge.
  task automatic send(input int s, input logic [7:0] d);
    case (s)
      1:       begin write1 = 1'b1; txdata1 = d; end
      2:       begin write2 = 1'b1; txdata2 = d; end
      default: begin write0 = 1'b0; write0 = 1'b1; txdata0 = d; end
    endcase
    @(negedge clk);
    write0 = 1'b0;
    write1 = 1'b0;
    write2 = 1'b0;
  endtask

  // Wait (bounded) for txd to fall on the selected instance, then sample
  // nbits bit times and compare them with exp.
  task automatic capture(input string name, input int nbits, input logic [23:0] exp);
    logic [23:0] obs;
    int          dev;
    int          waited;
    bit          found;
    obs    = '0;
    dev    = 0;
    waited = 0;
    found  = 1'b0;
    while (!found && waited < 200) begin
      @(negedge clk);
      waited++;
      if (txd_s === 1'b0) found = 1'b1;
    end
    start_wait    = waited;
    start_txempty = txempty_s;
    start_busy    = busy_s;
    check({name, " start seen"}, 32'(found), 32'd1);
    if (found) begin
      for (int j = 0; j < nbits * DIV; j++) begin
        if (j > 0) @(negedge clk);
        if (txd_s !== exp[j / DIV]) dev++;
        if (j % DIV == DIV / 2) obs[j / DIV] = txd_s;
      end
    end
    check({name, " frame"}, 32'(obs), 32'(exp));
    check({name, " bit timing deviations"}, 32'(dev), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int t;

    tbl[0] = '{0, 8'h00, 10, 24'(10'b1_00000000_0)};
    tbl[1] = '{0, 8'hFF, 10, 24'(10'b1_11111111_0)};
    tbl[2] = '{0, 8'h80, 10, 24'(10'b1_10000000_0)};
    tbl[3] = '{0, 8'h01, 10, 24'(10'b1_00000001_0)};
    tbl[4] = '{1, 8'h07, 11, 24'(11'b1_1_00000111_0)};   // even parity 1
    tbl[5] = '{1, 8'hFF, 11, 24'(11'b1_0_11111111_0)};   // even parity 0
    tbl[6] = '{2, 8'h07, 12, 24'(12'b11_0_00000111_0)};  // odd parity 0, 2 stops
    tbl[7] = '{2, 8'h00, 12, 24'(12'b11_1_00000000_0)};  // odd parity 1, 2 stops

    rst     = 1'b1;
    sel     = 0;
    write0  = 1'b0; write1  = 1'b0; write2  = 1'b0;
    txdata0 = '0;   txdata1 = '0;   txdata2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Test 1: idle after reset.
    @(negedge clk);
    check("reset txd", 32'(txd0), 32'd1);
    check("reset txempty", 32'(txempty0), 32'd1);
    check("reset busy", 32'(busy0), 32'd0);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (txd0 !== 1'b1 || txempty0 !== 1'b1 || busy0 !== 1'b0) bad++;
    end
    check("idle 100 cycles bad samples", 32'(bad), 32'd0);

    // Test 2: write 0x55, check latency and the whole frame.
    sel = 0;
    send(0, 8'h55);
    check("w55 txempty after accept", 32'(txempty_s), 32'd0);
    check("w55 busy before start", 32'(busy_s), 32'd0);
    check("w55 txd before start", 32'(txd_s), 32'd1);
    capture("w55", 10, 24'(10'b1_01010101_0));
    check("w55 start latency cycles", 32'(start_wait), 32'd1);
    check("w55 txempty at start", 32'(start_txempty), 32'd1);
    check("w55 busy at start", 32'(start_busy), 32'd1);
    @(negedge clk);
    check("w55 busy after stop", 32'(busy_s), 32'd0);
    check("w55 txd after stop", 32'(txd_s), 32'd1);

    // Table vectors: single frames across all three configurations.
    for (int i = 0; i < 8; i++) begin
      sel = tbl[i].sel;
      send(tbl[i].sel, tbl[i].data);
      capture($sformatf("vec%0d", i), tbl[i].nbits, tbl[i].exp);
      @(negedge clk);
      check($sformatf("vec%0d busy after frame", i), 32'(busy_s), 32'd0);
    end
    sel = 0;

    // Test 3: back-to-back frames 0xA3 then 0x0F with no idle gap.
    send(0, 8'hA3);
    fork
      capture("b2b", 20, 24'({10'b1_00001111_0, 10'b1_10100011_0}));
      begin
        t = 0;
        while (txempty_s !== 1'b1 && t < 50) begin
          @(negedge clk);
          t++;
        end
        send(0, 8'h0F);
      end
    join
    @(negedge clk);
    check("b2b busy after frames", 32'(busy_s), 32'd0);

    // Test 4: a write while txempty=0 is dropped.
    send(0, 8'h11);
    fork
      capture("drop", 20, 24'({10'b1_00100010_0, 10'b1_00010001_0}));
      begin
        check("drop txempty low at 2nd write", 32'(txempty_s), 32'd0);
        send(0, 8'hFF);
        send(0, 8'h22);
      end
    join
    @(negedge clk);
    check("drop busy after frames", 32'(busy_s), 32'd0);

    // Test 6: asynchronous reset in the middle of the data bits of 0x00.
    send(0, 8'h00);
    repeat (8) @(negedge clk);
    check("mid-frame txd low", 32'(txd_s), 32'd0);
    check("mid-frame busy", 32'(busy_s), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async reset txd", 32'(txd_s), 32'd1);
    check("async reset busy", 32'(busy_s), 32'd0);
    check("async reset txempty", 32'(txempty_s), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset txd", 32'(txd_s), 32'd1);
    check("post-reset txempty", 32'(txempty_s), 32'd1);
    check("post-reset busy", 32'(busy_s), 32'd0);
    send(0, 8'h3C);
    capture("post-reset 3C", 10, 24'(10'b1_00111100_0));
    @(negedge clk);
    check("post-reset 3C busy after", 32'(busy_s), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
